vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single VRAM port (sel/wr/mask/addr/data, ack handshake) among NUM_REQ masters
//  (test pattern generator, rasterizer, CPU bridge). One transaction is in flight at a time.
//  Grant order is round-robin by default. The block sits between the masters and the VRAM controller.
// PARAMETERS
//  NUM_REQ  3   number of requesters, 2..8
//  ADDR_W   32  VRAM address width
//  DATA_W   16  VRAM data width
// PORTS
//  clk              in   1               single clock domain
//  reset_i          in   1               synchronous, active-high reset
//  req_sel_i        in   NUM_REQ         per-requester request (held until acked)
//  req_wr_i         in   NUM_REQ         per-requester 1=write, 0=read
//  req_mask_i       in   NUM_REQ*4       per-requester byte mask, slice [4*i+:4]
//  req_addr_i       in   NUM_REQ*ADDR_W  per-requester address, slice [ADDR_W*i+:ADDR_W]
//  req_data_i       in   NUM_REQ*DATA_W  per-requester write data
//  req_ack_o        out  NUM_REQ         one-hot ack, combinational: vram_ack_i & BUSY & grant
//  req_data_o       out  DATA_W          read data broadcast (vram_data_in_i pass-through)
//  vram_ack_i       in   1               VRAM transaction complete
//  vram_data_in_i   in   DATA_W          VRAM read data, valid with vram_ack_i
//  vram_sel_o       out  1               registered, to VRAM
//  vram_wr_o        out  1               registered
//  vram_mask_o      out  4               registered
//  vram_addr_o      out  ADDR_W          registered
//  vram_data_out_o  out  DATA_W          registered
//  grant_o          out  $clog2(NUM_REQ) index of the current/last granted requester
//  busy_o           out  1               1 while in BUSY
// BEHAVIOUR
//  States: IDLE, BUSY.
//  Reset: state=IDLE; vram_sel_o=0; vram_wr_o=0; vram_mask_o=4'hF; vram_addr_o=0;
//   vram_data_out_o=0; grant_o=0; busy_o=0; last pointer=NUM_REQ-1, so requester 0 wins first.
//  IDLE: if any req_sel_i is set, select the winner w and latch its wr/mask/addr/data into the vram_*
//   registers. Set vram_sel_o=1, grant_o=w, last=w, and go to BUSY. Latency: request -> vram_sel_o is 1 cycle.
//  Round-robin: search indices last+1 .. last+NUM_REQ, modulo NUM_REQ; first set bit wins.
//  BUSY: downstream outputs are held stable and other requests are ignored.
//   When vram_ack_i=1: req_ack_o[grant_o]=1 in the same cycle, vram_sel_o<=0, vram_wr_o<=0, go to IDLE.
//  Requester rule: a requester must drop req_sel_i in the cycle after it sees ack (registered drop).
//   IDLE then samples an already-released request, so a completed transaction is never re-issued.
//  Throughput: at most one transaction per 2 cycles (IDLE + BUSY with same-cycle ack).
//  vram_ack_i in IDLE is ignored; req_ack_o stays 0.
//  A req_sel_i deassert while BUSY does not abort; the transaction completes and the ack is still pulsed.
//  A new request arriving in the ack cycle is considered in the following IDLE cycle.
//  reset_i mid-transaction: vram_sel_o drops next edge, no ack is issued, pointer returns to NUM_REQ-1.
//  The VRAM controller must tolerate the abandoned access.
//  req_data_o = vram_data_in_i at all times; valid only when the requester's ack is high.
// CONFIGURATION
//  VRAM_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest set index always wins and the last
//   pointer is unused. Undefined (default): round-robin as above. Handshake and timing are identical.
// TESTING
//  1. Reset, req_sel_i=3'b001, addr 0x10, data 0x0FFF, ack after 2 cycles -> vram_sel_o=1 one cycle
//     after request, vram_addr_o=0x10, vram_data_out_o=0x0FFF, req_ack_o=3'b001 on the ack cycle.
//  2. req_sel_i=3'b111 held, ack 1 cycle after each sel -> grant order 0,1,2,0,1,2. With the macro
//     defined, each requester drops sel after its ack, giving order 0,1,2; when 0 re-requests it is served first.
//  3. Requester 1 streams back-to-back (re-asserts 1 cycle after drop) while 2 also requests ->
//     grants alternate 1,2,1,2; no requester starves.
//  4. Read: req_wr_i=0, vram_data_in_i=0xABCD with ack -> req_data_o=0xABCD, vram_wr_o=0 throughout.
//  5. reset_i asserted during BUSY before ack -> vram_sel_o=0 next cycle, req_ack_o never pulses,
//     next grant goes to requester 0.
//  6. Spurious vram_ack_i in IDLE with no requests -> req_ack_o=0, state stays IDLE, outputs unchanged.

Source files
------------

// File: rtl/vram_arbiter.sv
// Shares one VRAM port among NUM_REQ masters, one transaction in flight at a time.
// Round-robin by default; define VRAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module vram_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_sel_i,
    input  logic [NUM_REQ-1:0]        req_wr_i,
    input  logic [NUM_REQ*4-1:0]      req_mask_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ack_o,
    output logic [DATA_W-1:0]         req_data_o,
    input  logic                      vram_ack_i,
    input  logic [DATA_W-1:0]         vram_data_in_i,
    output logic                      vram_sel_o,
    output logic                      vram_wr_o,
    output logic [3:0]                vram_mask_o,
    output logic [ADDR_W-1:0]         vram_addr_o,
    output logic [DATA_W-1:0]         vram_data_out_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_o,
    output logic                      busy_o
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t              r_state;
    logic                r_vram_sel;
    logic                r_vram_wr;
    logic [3:0]          r_vram_mask;
    logic [ADDR_W-1:0]   r_vram_addr;
    logic [DATA_W-1:0]   r_vram_data;
    logic [GW-1:0]       r_grant;

    logic [3:0]          w_mask [NUM_REQ];
    logic [ADDR_W-1:0]   w_addr [NUM_REQ];
    logic [DATA_W-1:0]   w_data [NUM_REQ];
    logic [GW-1:0]       w_winner;
    logic                w_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_mask[gi]    = req_mask_i[4*gi +: 4];
            assign w_addr[gi]    = req_addr_i[ADDR_W*gi +: ADDR_W];
            assign w_data[gi]    = req_data_i[DATA_W*gi +: DATA_W];
            assign req_ack_o[gi] = vram_ack_i & (r_state == S_BUSY) & (r_grant == GW'(gi));
        end
    endgenerate

    assign w_any = |req_sel_i;

`ifdef VRAM_ARB_FIXED_PRIO_EN
    // Walk from the top so the lowest set index is the last assignment.
    always_comb begin
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_sel_i[k]) w_winner = GW'(k);
        end
    end
`else
    logic [GW-1:0] r_last;
    logic [GW-1:0] w_rr_idx [NUM_REQ];

    // w_rr_idx[k] is the (k+1)-th candidate after the last winner.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rr
            assign w_rr_idx[gi] = GW'((int'(r_last) + gi + 1) % NUM_REQ);
        end
    endgenerate

    always_comb begin
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_sel_i[w_rr_idx[k]]) w_winner = w_rr_idx[k];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_vram_sel  <= 1'b0;
            r_vram_wr   <= 1'b0;
            r_vram_mask <= 4'hF;
            r_vram_addr <= '0;
            r_vram_data <= '0;
            r_grant     <= '0;
`ifndef VRAM_ARB_FIXED_PRIO_EN
            r_last      <= GW'(NUM_REQ - 1);
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_vram_sel  <= 1'b1;
                        r_vram_wr   <= req_wr_i[w_winner];
                        r_vram_mask <= w_mask[w_winner];
                        r_vram_addr <= w_addr[w_winner];
                        r_vram_data <= w_data[w_winner];
                        r_grant     <= w_winner;
`ifndef VRAM_ARB_FIXED_PRIO_EN
                        r_last      <= w_winner;
`endif
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Outputs stay frozen until the controller completes the access.
                    if (vram_ack_i) begin
                        r_vram_sel <= 1'b0;
                        r_vram_wr  <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_data_o      = vram_data_in_i;
    assign vram_sel_o      = r_vram_sel;
    assign vram_wr_o       = r_vram_wr;
    assign vram_mask_o     = r_vram_mask;
    assign vram_addr_o     = r_vram_addr;
    assign vram_data_out_o = r_vram_data;
    assign grant_o         = r_grant;
    assign busy_o          = (r_state == S_BUSY);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter (3 requesters, 32-bit address, 16-bit data).
module tb_vram_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [N-1:0]      req_sel_i;
    logic [N-1:0]      req_wr_i;
    logic [N*4-1:0]    req_mask_i;
    logic [N*AW-1:0]   req_addr_i;
    logic [N*DW-1:0]   req_data_i;
    logic [N-1:0]      req_ack_o;
    logic [DW-1:0]     req_data_o;
    logic              vram_ack_i;
    logic [DW-1:0]     vram_data_in_i;
    logic              vram_sel_o;
    logic              vram_wr_o;
    logic [3:0]        vram_mask_o;
    logic [AW-1:0]     vram_addr_o;
    logic [DW-1:0]     vram_data_out_o;
    logic [1:0]        grant_o;
    logic              busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk             (clk),
        .reset_i         (reset_i),
        .req_sel_i       (req_sel_i),
        .req_wr_i        (req_wr_i),
        .req_mask_i      (req_mask_i),
        .req_addr_i      (req_addr_i),
        .req_data_i      (req_data_i),
        .req_ack_o       (req_ack_o),
        .req_data_o      (req_data_o),
        .vram_ack_i      (vram_ack_i),
        .vram_data_in_i  (vram_data_in_i),
        .vram_sel_o      (vram_sel_o),
        .vram_wr_o       (vram_wr_o),
        .vram_mask_o     (vram_mask_o),
        .vram_addr_o     (vram_addr_o),
        .vram_data_out_o (vram_data_out_o),
        .grant_o         (grant_o),
        .busy_o          (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from an IDLE cycle with requests present; ack in the first BUSY cycle.
    task automatic serve(input int g, input logic [N-1:0] sel_busy, input logic [N-1:0] sel_after);
        tick();
        req_sel_i = sel_busy;
        chk("serve_sel_up", 64'(vram_sel_o), 64'd1);
        chk("serve_grant", 64'(grant_o), 64'(g));
        chk("serve_addr", 64'(vram_addr_o), 64'(32'h100 * (g + 1)));
        vram_ack_i = 1'b1;
        #1;
        chk("serve_ack", 64'(req_ack_o), 64'(1 << g));
        tick();
        vram_ack_i = 1'b0;
        req_sel_i  = sel_after;
        #1;
        chk("serve_sel_down", 64'(vram_sel_o), 64'd0);
        chk("serve_ack_low", 64'(req_ack_o), 64'd0);
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i        = 1'b1;
        req_sel_i      = '0;
        req_wr_i       = '1;
        vram_ack_i     = 1'b0;
        vram_data_in_i = '0;
        for (int i = 0; i < N; i++) begin
            req_mask_i[4*i +: 4]  = 4'(i + 1);
            req_addr_i[AW*i +: AW] = 32'h100 * (i + 1);
            req_data_i[DW*i +: DW] = DW'(16'h1111 * (i + 1));
        end
        tick();
        tick();
        chk("rst_sel", 64'(vram_sel_o), 64'd0);
        chk("rst_wr", 64'(vram_wr_o), 64'd0);
        chk("rst_mask", 64'(vram_mask_o), 64'hF);
        chk("rst_addr", 64'(vram_addr_o), 64'd0);
        chk("rst_data", 64'(vram_data_out_o), 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ack", 64'(req_ack_o), 64'd0);

        // Single write from requester 0, acked two BUSY cycles in.
        req_addr_i[31:0] = 32'h10;
        req_data_i[15:0] = 16'h0FFF;
        reset_i   = 1'b0;
        req_sel_i = 3'b001;
        #1;
        chk("t1_sel_before", 64'(vram_sel_o), 64'd0);
        tick();
        chk("t1_sel", 64'(vram_sel_o), 64'd1);
        chk("t1_addr", 64'(vram_addr_o), 64'h10);
        chk("t1_data", 64'(vram_data_out_o), 64'h0FFF);
        chk("t1_wr", 64'(vram_wr_o), 64'd1);
        chk("t1_mask", 64'(vram_mask_o), 64'h1);
        chk("t1_busy", 64'(busy_o), 64'd1);
        chk("t1_ack_wait", 64'(req_ack_o), 64'd0);
        tick();
        chk("t1_sel_held", 64'(vram_sel_o), 64'd1);
        vram_ack_i = 1'b1;
        #1;
        chk("t1_ack", 64'(req_ack_o), 64'b001);
        tick();
        vram_ack_i = 1'b0;
        req_sel_i  = '0;
        #1;
        chk("t1_sel_drop", 64'(vram_sel_o), 64'd0);
        chk("t1_wr_drop", 64'(vram_wr_o), 64'd0);
        chk("t1_busy_drop", 64'(busy_o), 64'd0);
        req_addr_i[31:0] = 32'h100;
        req_data_i[15:0] = 16'h1111;

        // All three requesting.
        pulse_reset();
`ifdef VRAM_ARB_FIXED_PRIO_EN
        req_sel_i = 3'b111;
        serve(0, 3'b111, 3'b110);
        serve(1, 3'b110, 3'b100);
        serve(2, 3'b101, 3'b001);
        serve(0, 3'b001, 3'b000);
`else
        req_sel_i = 3'b111;
        serve(0, 3'b111, 3'b111);
        serve(1, 3'b111, 3'b111);
        serve(2, 3'b111, 3'b111);
        serve(0, 3'b111, 3'b111);
        serve(1, 3'b111, 3'b111);
        serve(2, 3'b111, 3'b000);
`endif

        // Requester 1 streaming against requester 2.
        pulse_reset();
        req_sel_i = 3'b110;
        serve(1, 3'b110, 3'b100);
        serve(2, 3'b110, 3'b010);
        serve(1, 3'b110, 3'b100);
        serve(2, 3'b110, 3'b000);

        // Read from requester 0.
        req_wr_i[0] = 1'b0;
        req_sel_i   = 3'b001;
        tick();
        chk("t4_sel", 64'(vram_sel_o), 64'd1);
        chk("t4_wr", 64'(vram_wr_o), 64'd0);
        chk("t4_grant", 64'(grant_o), 64'd0);
        vram_data_in_i = 16'hABCD;
        vram_ack_i     = 1'b1;
        #1;
        chk("t4_rdata", 64'(req_data_o), 64'hABCD);
        chk("t4_ack", 64'(req_ack_o), 64'b001);
        chk("t4_wr_ack", 64'(vram_wr_o), 64'd0);
        tick();
        vram_ack_i = 1'b0;
        req_sel_i  = '0;
        #1;
        chk("t4_wr_after", 64'(vram_wr_o), 64'd0);
        chk("t4_sel_after", 64'(vram_sel_o), 64'd0);
        req_wr_i = '1;

        // Reset while BUSY.
        req_sel_i = 3'b010;
        tick();
        chk("t5_sel", 64'(vram_sel_o), 64'd1);
        chk("t5_grant", 64'(grant_o), 64'd1);
        reset_i = 1'b1;
        #1;
        chk("t5_ack_pre", 64'(req_ack_o), 64'd0);
        tick();
        chk("t5_sel_drop", 64'(vram_sel_o), 64'd0);
        chk("t5_busy", 64'(busy_o), 64'd0);
        chk("t5_grant_rst", 64'(grant_o), 64'd0);
        vram_ack_i = 1'b1;
        #1;
        chk("t5_ack_rst", 64'(req_ack_o), 64'd0);
        vram_ack_i = 1'b0;
        reset_i    = 1'b0;
        req_sel_i  = 3'b111;
        serve(0, 3'b111, 3'b000);

        // Spurious ack in IDLE.
        vram_ack_i = 1'b1;
        #1;
        chk("t6_ack", 64'(req_ack_o), 64'd0);
        chk("t6_busy", 64'(busy_o), 64'd0);
        tick();
        chk("t6_busy_after", 64'(busy_o), 64'd0);
        chk("t6_sel", 64'(vram_sel_o), 64'd0);
        chk("t6_addr", 64'(vram_addr_o), 64'h100);
        chk("t6_data", 64'(vram_data_out_o), 64'h1111);
        chk("t6_grant", 64'(grant_o), 64'd0);
        chk("t6_ack_after", 64'(req_ack_o), 64'd0);
        vram_ack_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
